sha3_state_serializer: RTL

SHA3_STATE_SERIALIZER -- requirements
Module: sha3_state_serializer

---
 rtl/sha3_state_serializer.sv | 112 +++++++++++
 1 files changed

// File: rtl/sha3_state_serializer.sv
// Captures a 25-lane Keccak state on a sample strobe and streams OUT_WORDS
// lanes as a valid/ready stream. Samples arriving while a stream is still
// in progress are dropped, and that is recorded in a sticky overflow flag.
module sha3_state_serializer #(
  parameter int OUT_WORDS = 25
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         sample,
  input  logic [319:0] isa,
  input  logic [319:0] isb,
  input  logic [319:0] isc,
  input  logic [319:0] isd,
  input  logic [319:0] ise,
  output logic         iready,
  output logic         ovalid,
  output logic [63:0]  odata,
  output logic         olast,
  input  logic         oready,
  output logic         overflow
);

  if (OUT_WORDS < 1 || OUT_WORDS > 25) begin : g_bad_out_words
    $error("sha3_state_serializer: OUT_WORDS must be in 1..25");
  end

  localparam logic [4:0] LAST_IDX = 5'(OUT_WORDS - 1);

  // Handshake: a lane moves downstream on any cycle with ovalid && oready.
  // While ovalid is high and oready low, odata/olast hold. A new state is
  // accepted only when idle or when the final lane is transferring.
  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  state_t       state;
  state_t       state_n;
  logic [4:0]   idx;
  logic [4:0]   idx_n;
  logic [63:0]  lanes [25];
  logic [319:0] slice [5];
  logic         capture;
  logic         xfer;

  assign slice[0] = isa;
  assign slice[1] = isb;
  assign slice[2] = isc;
  assign slice[3] = isd;
  assign slice[4] = ise;

  assign ovalid  = (state == EMIT);
  assign olast   = ovalid && (idx == LAST_IDX);
  assign iready  = (state == IDLE) || (ovalid && olast && oready);
  assign capture = sample && iready;
  assign xfer    = ovalid && oready;
  assign odata   = lanes[idx];

  always_comb begin
    state_n = state;
    idx_n   = idx;
    case (state)
      IDLE: begin
        if (capture) begin
          state_n = EMIT;
          idx_n   = 5'd0;
        end
      end
      EMIT: begin
        if (xfer) begin
          if (!olast) begin
            idx_n = idx + 5'd1;
          end else if (capture) begin
            // Restart on the new state in the same cycle: no idle bubble.
            idx_n = 5'd0;
          end else begin
            state_n = IDLE;
            idx_n   = 5'd0;
          end
        end
      end
      default: begin
        state_n = IDLE;
        idx_n   = 5'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= 5'd0;
      overflow <= 1'b0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      if (sample && !iready) begin
        overflow <= 1'b1;
      end
    end
  end

  // The lane buffer is deliberately left out of reset; it is only read in EMIT.
  always_ff @(posedge clk) begin
    if (!rst && capture) begin
      for (int i = 0; i < 25; i++) begin
        lanes[i] <= slice[i / 5][(i % 5) * 64 +: 64];
      end
    end
  end

endmodule
